hex_display_scanner: RTL and testbench

//  Time-multiplexed scan controller feeding the 7-segment decoder stage.
//  - Holds an N_DIGITS-wide hex value and presents one nibble at a time on digit_val,

---
 rtl/hex_display_scanner.sv | 115 +++++++++++
 tb/tb_hex_display_scanner.sv | 136 +++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex scan controller: one nibble per slot, active-low digit enables.
// Optional LEADING_ZERO_BLANK_EN suppresses enables of leading zero digits (digit 0 always shown).
module hex_display_scanner #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic                  blank,
  output logic [3:0]            digit_val,
  output logic [N_DIGITS-1:0]   digit_sel_n,
  output logic                  frame_done
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [DIV_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] pend;
  logic                  pend_vld;
  logic [4*N_DIGITS-1:0] disp;

  logic                  slot_end;
  logic                  frame_wrap;
  logic [3:0]            cur_nib;
  logic [N_DIGITS-1:0]   slot_sel_n;
  logic                  suppress;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  // A load landing on the wrap cycle bypasses pend so it shows in the frame that starts now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= '0;
      pend_vld <= 1'b0;
      disp     <= '0;
    end else begin
      if (load) begin
        if (frame_wrap) begin
          disp     <= data_in;
          pend_vld <= 1'b0;
        end else begin
          pend     <= data_in;
          pend_vld <= 1'b1;
        end
      end else if (frame_wrap && pend_vld) begin
        disp     <= pend;
        pend_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    cur_nib    = '0;
    slot_sel_n = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib       = disp[4*k +: 4];
        slot_sel_n[k] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lead_zero;
  logic                above_zero;

  always_comb begin
    lead_zero  = '0;
    above_zero = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      above_zero   = above_zero && (disp[4*k +: 4] == 4'h0);
      lead_zero[k] = above_zero;
    end
  end

  assign suppress = |(lead_zero & ~slot_sel_n);
`else
  assign suppress = 1'b0;
`endif

  // cnt==0 is the per-slot dead cycle that keeps the previous digit from ghosting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_val   <= '0;
      digit_sel_n <= '1;
      frame_done  <= 1'b0;
    end else begin
      digit_val   <= cur_nib;
      digit_sel_n <= (blank || (cnt == '0) || suppress) ? '1 : slot_sel_n;
      frame_done  <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with N_DIGITS=4, REFRESH_DIV=4.
// Checks every cycle of each frame against hand-derived slot patterns.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  digit_val;
  logic [3:0]  digit_sel_n;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .N_DIGITS   (4),
    .REFRESH_DIV(4),
    .DIV_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .blank      (blank),
    .digit_val  (digit_val),
    .digit_sel_n(digit_sel_n),
    .frame_done (frame_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit k set: digit k is a leading zero whose enable must stay high.
  function automatic logic [3:0] lz_mask(input logic [15:0] v);
    logic [3:0] m;
    logic       z;
    m = 4'b0000;
    z = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 3; k > 0; k--) begin
      z    = z && (v[4*k +: 4] == 4'h0);
      m[k] = z;
    end
`endif
    return m;
  endfunction

  // Runs one full frame from a frame boundary; optional loads at cycle ld_a / ld_b.
  task automatic check_frame(input string tag, input logic [15:0] shown, input logic blk,
                             input int ld_a, input logic [15:0] va,
                             input int ld_b, input logic [15:0] vb);
    logic [3:0] m;
    logic [3:0] exp_sel;
    logic [3:0] one;
    int         d;
    m     = lz_mask(shown);
    one   = 4'b0001;
    blank = blk;
    for (int i = 0; i < 16; i++) begin
      if (i == ld_a) begin
        load    = 1'b1;
        data_in = va;
      end else if (i == ld_b) begin
        load    = 1'b1;
        data_in = vb;
      end
      tick();
      load = 1'b0;
      d = i / 4;
      if (blk || (i % 4) == 0 || m[d]) exp_sel = 4'hF;
      else exp_sel = ~(one << d);
      check_val($sformatf("%s sel c%0d", tag, i), 32'(digit_sel_n), 32'(exp_sel));
      check_val($sformatf("%s val c%0d", tag, i), 32'(digit_val), 32'(shown[4*d +: 4]));
      check_val($sformatf("%s fdone c%0d", tag, i), 32'(frame_done), 32'(i == 15));
    end
  endtask

  initial begin
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst val", 32'(digit_val), 32'h0);
    check_val("rst sel", 32'(digit_sel_n), 32'hF);
    check_val("rst fdone", 32'(frame_done), 32'h0);
    reset = 1'b0;

    check_frame("f0_zero_load1234", 16'h0000, 1'b0, 5, 16'h1234, -1, 16'h0000);
    check_frame("f1_1234_overwr", 16'h1234, 1'b0, 2, 16'hAAAA, 9, 16'hBEEF);
    check_frame("f2_beef_coinc", 16'hBEEF, 1'b0, 15, 16'h5678, -1, 16'h0000);
    check_frame("f3_5678", 16'h5678, 1'b0, -1, 16'h0000, -1, 16'h0000);
    check_frame("f4_no_extra", 16'h5678, 1'b0, -1, 16'h0000, -1, 16'h0000);
    check_frame("f5_blank_load", 16'h5678, 1'b1, 6, 16'h0C0D, -1, 16'h0000);
    check_frame("f6_blank", 16'h0C0D, 1'b1, -1, 16'h0000, -1, 16'h0000);
    check_frame("f7_unblank", 16'h0C0D, 1'b0, -1, 16'h0000, -1, 16'h0000);

    // Mid-frame reset with a load still pending.
    load    = 1'b1;
    data_in = 16'h9999;
    tick();
    load = 1'b0;
    tick();
    check_val("pre_rst sel", 32'(digit_sel_n), 32'hE);
    check_val("pre_rst val", 32'(digit_val), 32'hD);
    reset = 1'b1;
    #1;
    check_val("mid_rst val", 32'(digit_val), 32'h0);
    check_val("mid_rst sel", 32'(digit_sel_n), 32'hF);
    check_val("mid_rst fdone", 32'(frame_done), 32'h0);
    tick();
    reset = 1'b0;

    check_frame("f8_post_rst", 16'h0000, 1'b0, -1, 16'h0000, -1, 16'h0000);
    check_frame("f9_pend_gone", 16'h0000, 1'b0, 3, 16'h00A0, -1, 16'h0000);
    check_frame("f10_00a0", 16'h00A0, 1'b0, 0, 16'h0000, -1, 16'h0000);
    check_frame("f11_0000", 16'h0000, 1'b0, -1, 16'h0000, -1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
